// File: rtl/sticky_bit_gen.sv
// Sticky-bit generator: OR-reduces the discarded mantissa product bits through a
// grouped tree, with a combinational flag and a valid-qualified registered copy.
module sticky_bit_gen #(
    parameter int WIDTH = 23,
    parameter int GROUP = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [WIDTH-1:0]                     leastbits,
    input  logic                                 valid_in,
    output logic                                 sticky,
    output logic                                 sticky_q,
    output logic                                 valid_out,
    output logic [(WIDTH+GROUP-1)/GROUP-1:0]     group_nz
);

    localparam int NGRP = (WIDTH + GROUP - 1) / GROUP;

    logic sticky_q_d;
    logic valid_out_d;

    // Leaf groups start at bit 0; the last group takes whatever upper bits remain.
    for (genvar g = 0; g < NGRP; g++) begin : g_leaf
        localparam int LO = g * GROUP;
        localparam int HI = ((LO + GROUP) > WIDTH) ? (WIDTH - 1) : (LO + GROUP - 1);
        assign group_nz[g] = |leastbits[HI:LO];
    end

    assign sticky = |group_nz;

    always_comb begin
        valid_out_d = valid_in;
        sticky_q_d  = valid_in ? sticky : sticky_q;
    end

    // Stage 0 -> 1: result only advances on valid operands; reset drops both flags at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            sticky_q  <= sticky_q_d;
            valid_out <= valid_out_d;
        end
    end

endmodule

// File: tb/tb_sticky_bit_gen.sv
// Scoreboard bench for sticky_bit_gen: driver checks the combinational outputs and
// queues expected registered results; a monitor pops and compares after each edge.
module tb_sticky_bit_gen;

    localparam int WIDTH = 23;
    localparam int GROUP = 4;
    localparam int NGRP  = (WIDTH + GROUP - 1) / GROUP;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] leastbits;
    logic             valid_in;
    logic             sticky;
    logic             sticky_q;
    logic             valid_out;
    logic [NGRP-1:0]  group_nz;

    sticky_bit_gen #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk       (clk),
        .rst       (rst),
        .leastbits (leastbits),
        .valid_in  (valid_in),
        .sticky    (sticky),
        .sticky_q  (sticky_q),
        .valid_out (valid_out),
        .group_nz  (group_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic sq;
        logic vo;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 0;
    logic exp_sq   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: a discarded tail is sticky iff it is nonzero; group flags come from
    // integer division of each set bit position.
    function automatic logic [NGRP-1:0] model_groups(input logic [WIDTH-1:0] v);
        logic [NGRP-1:0] g;
        g = '0;
        for (int b = 0; b < WIDTH; b++)
            if (v[b]) g[b / GROUP] = 1'b1;
        return g;
    endfunction

    task automatic drive(input logic [WIDTH-1:0] v, input logic vld);
        exp_t e;
        @(negedge clk);
        leastbits = v;
        valid_in  = vld;
        #1;
        check("sticky", {31'd0, sticky}, {31'd0, (v != 0)});
        check("group_nz", {{(32-NGRP){1'b0}}, group_nz}, {{(32-NGRP){1'b0}}, model_groups(v)});
        if (vld) exp_sq = (v != 0);
        e.sq = exp_sq;
        e.vo = vld;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en && q.size() > 0) begin
            e = q.pop_front();
            check("valid_out", {31'd0, valid_out}, {31'd0, e.vo});
            check("sticky_q", {31'd0, sticky_q}, {31'd0, e.sq});
        end
    end

    initial begin
        logic [WIDTH-1:0] v;
        int               waited;

        rst       = 1'b1;
        valid_in  = 1'b0;
        leastbits = '0;
        #1;
        check("reset sticky_q", {31'd0, sticky_q}, 32'd0);
        check("reset valid_out", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        exp_sq = 1'b0;
        mon_en = 1;

        drive(23'h000000, 1'b1);
        drive(23'h000002, 1'b1);
        drive(23'h008002, 1'b1);
        drive(23'h7FFFFF, 1'b1);
        for (int b = 0; b < WIDTH; b++) begin
            v = '0;
            v[b] = 1'b1;
            drive(v, 1'b1);
        end
        drive(23'h400000, 1'b1);
        drive(23'h000000, 1'b0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: v = '0;
                1: begin v = '0; v[$urandom_range(0, WIDTH-1)] = 1'b1; end
                default: v = WIDTH'($urandom);
            endcase
            drive(v, 1'($urandom_range(0, 1)));
        end

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        check("scoreboard drained", q.size(), 32'd0);
        mon_en = 0;

        // Asynchronous reset landing between edges while a valid result is held.
        @(negedge clk);
        leastbits = 23'h000100;
        valid_in  = 1'b1;
        @(posedge clk);
        #2;
        check("pre-reset sticky_q", {31'd0, sticky_q}, 32'd1);
        check("pre-reset valid_out", {31'd0, valid_out}, 32'd1);
        rst = 1'b1;
        #1;
        check("async rst sticky_q", {31'd0, sticky_q}, 32'd0);
        check("async rst valid_out", {31'd0, valid_out}, 32'd0);
        check("sticky during rst", {31'd0, sticky}, 32'd1);
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("post-rst hold sticky_q", {31'd0, sticky_q}, 32'd0);
        check("post-rst valid_out", {31'd0, valid_out}, 32'd0);
        @(posedge clk);
        #1;
        check("post-rst hold2 sticky_q", {31'd0, sticky_q}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
